seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
//   Holds a packed BCD display word and applies new values only at frame boundaries (tear-free).
//   Sequences one digit at a time, with a blanking gap between digits (anti-ghosting) and
//   optional leading-zero suppression.
//   o_Value feeds the seven_seg decoder; o_Digit_En drives the digit anodes.
// PARAMETERS
//   NUM_DIGITS   4      digits scanned; >=2
//   ON_CYCLES    25000  clocks each digit is enabled; >=1
//   BLANK_CYCLES 250    clocks all digits are off between digits; >=1
// PORTS
//   i_Clk        in   1             system clock, all logic on rising edge
//   i_Rst_L      in   1             asynchronous reset, active low
//   i_Load       in   1             1-cycle strobe: capture i_Digits into staging register
//   i_Digits     in   4*NUM_DIGITS  packed BCD; [3:0] = digit 0 (least significant, rightmost)
//   i_Blank_Lead in   1             1 = suppress leading zeros (sampled every cycle)
//   o_Value      out  4             nibble to decoder; 4'hF = blank
//   o_Digit_En   out  NUM_DIGITS    active-low digit enables; at most one bit low at any time
//   o_Load_Ack   out  1             1-cycle pulse: staged value became the displayed value
// BEHAVIOUR
//   Reset (async, i_Rst_L=0):
//     o_Digit_En all 1s; o_Value=4'hF; o_Load_Ack=0.
//     State=BLANK, digit index=0, cycle counter=0, staged=0, shown=0, pending=0.
//   FSM, two states, one cycle counter (width clog2 of max(ON_CYCLES,BLANK_CYCLES)):
//     BLANK: all enables 1, o_Value=4'hF, for exactly BLANK_CYCLES cycles.
//       Then -> ON with the current index; counter cleared.
//     ON: o_Digit_En[idx]=0, others 1, for exactly ON_CYCLES cycles.
//       Then -> BLANK; idx <= idx+1, wrapping NUM_DIGITS-1 -> 0; counter cleared.
//   All outputs are registered and change on the same edge as the state change.
//   First digit-0 enable appears BLANK_CYCLES cycles after reset release.
//   Frame period = NUM_DIGITS*(ON_CYCLES+BLANK_CYCLES).
//   o_Value in ON = shown nibble idx, passed unchanged (values 10-15 blank in decoder).
//   Leading-zero suppression: if i_Blank_Lead=1, idx!=0, and shown nibbles idx..NUM_DIGITS-1
//     are all 0, then o_Value=4'hF. Digit 0 is never suppressed.
//   Load handshake:
//     i_Load=1 -> staged<=i_Digits, pending<=1. A repeat load while pending overwrites
//     staged; there is one ack per applied value, not one per load.
//   Frame boundary = last ON cycle of idx NUM_DIGITS-1.
//     If pending (or i_Load=1 on that cycle): shown<=value (i_Digits if i_Load this cycle,
//     else staged); pending<=0; o_Load_Ack=1 on the following cycle for exactly 1 cycle.
//     The new value is first visible on digit 0 of the next frame.
//   Reset mid-frame aborts immediately: display blanks and the staged value is discarded.
// TESTING (NUM_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2)
//   1. Reset release, no load -> enables all 1 for 2 clk.
//      Then 4'b1110 for 4 clk, 1111 x2, 1101 x4, ... period 24 clk.
//      o_Value = 0 on digit 0, 0 elsewhere.
//   2. i_Load with i_Digits=16'h1234 mid-frame -> no change until frame end.
//      o_Load_Ack pulses once. Next frame o_Value = 4,3,2,1 on digits 0..3.
//   3. i_Blank_Lead=1, shown=16'h0050 -> digits 0..3 show 0, 5, F, F.
//      With shown=16'h0000 -> 0, F, F, F.
//   4. Two loads (16'h1111 then 16'h2222) within one frame -> single ack; shows 2222.
//      A load on the frame-boundary cycle applies that value directly and acks.
//   5. Assert i_Rst_L=0 while digit 2 is enabled -> same cycle enables all 1, o_Value=F.
//      Pending load lost; after release the sequence restarts as in test 1.
//   6. Every cycle check: at most one o_Digit_En bit low.
//      o_Value=F whenever all enables are 1.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Frame-synchronous value update, blanking gap between digits, optional leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Digits,
  input  logic                    i_Blank_Lead,
  output logic [3:0]              o_Value,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Load_Ack
);

  localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic [IDX_W-1:0]        r_idx, w_idx_next;
  logic                    w_boundary;

  logic [4*NUM_DIGITS-1:0] r_staged, r_shown;
  logic                    r_pending;
  logic [3:0]              r_value, w_value_next;
  logic [NUM_DIGITS-1:0]   r_digit_en, w_digit_en_next;
  logic                    r_load_ack;
  logic [3:0]              w_nibble;
  logic                    w_upper_zero;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_idx;
    w_boundary   = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_next = ST_ON;
          w_cnt_next   = '0;
        end
      end
      ST_ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_next = ST_BLANK;
          w_cnt_next   = '0;
          w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          w_boundary   = (r_idx == IDX_LAST);
        end
      end
      default: begin
        w_state_next = ST_BLANK;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they change on the same edge as the FSM.
  always_comb begin
    w_nibble     = 4'h0;
    w_upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (r_idx == IDX_W'(j)) w_nibble = r_shown[4*j +: 4];
      if ((IDX_W'(j) >= r_idx) && (r_shown[4*j +: 4] != 4'h0)) w_upper_zero = 1'b0;
    end
    w_value_next    = 4'hF;
    w_digit_en_next = '1;
    if (w_state_next == ST_ON) begin
      w_digit_en_next[r_idx] = 1'b0;
      w_value_next = (i_Blank_Lead && (r_idx != '0) && w_upper_zero) ? 4'hF : w_nibble;
    end
  end

  // NOTE: staging/display words are reset as well, so a reset discards any pending value.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_staged   <= '0;
      r_shown    <= '0;
      r_pending  <= 1'b0;
      r_value    <= 4'hF;
      r_digit_en <= '1;
      r_load_ack <= 1'b0;
    end else begin
      r_value    <= w_value_next;
      r_digit_en <= w_digit_en_next;
      r_load_ack <= 1'b0;
      if (w_boundary && (r_pending || i_Load)) begin
        r_shown    <= i_Load ? i_Digits : r_staged;
        r_pending  <= 1'b0;
        r_load_ack <= 1'b1;
      end else if (i_Load) begin
        r_staged  <= i_Digits;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_Value    = r_value;
  assign o_Digit_En = r_digit_en;
  assign o_Load_Ack = r_load_ack;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (4 digits, 4 on-cycles, 2 blank-cycles, 24-clock frame).
// A negedge monitor checks every cycle against a small frame-phase model; tasks add hand checks.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic        i_Load = 1'b0;
  logic [15:0] i_Digits = 16'h0;
  logic        i_Blank_Lead = 1'b0;
  logic [3:0]  o_Value;
  logic [3:0]  o_Digit_En;
  logic        o_Load_Ack;

  int          n_vec = 0;
  int          n_bad = 0;
  int          q = 22;
  int          ack_cnt = 0;
  bit          track = 1'b0;
  logic [15:0] cap_w = 16'h0;
  logic [15:0] m_shown = 16'h0;
  logic [15:0] m_staged = 16'h0;
  bit          m_pending = 1'b0;
  bit          m_ack = 1'b0;
  bit          m_bl = 1'b0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .i_Clk(clk), .i_Rst_L(i_Rst_L), .i_Load(i_Load), .i_Digits(i_Digits),
    .i_Blank_Lead(i_Blank_Lead), .o_Value(o_Value), .o_Digit_En(o_Digit_En),
    .o_Load_Ack(o_Load_Ack)
  );

  always #5 clk = ~clk;

  // Phase q: digit q/6 is on for q%6 in 0..3, blank for 4..5; q=21 is the frame boundary cycle.
  function automatic logic [3:0] exp_en(int p);
    if (p % 6 < 4) return ~(4'b0001 << (p / 6));
    return 4'hF;
  endfunction

  function automatic logic [3:0] exp_val(int p);
    int d;
    logic [15:0] up;
    d = p / 6;
    if (p % 6 >= 4) return 4'hF;
    up = m_shown >> (4 * d);
    if (m_bl && d != 0 && up == 16'h0) return 4'hF;
    return m_shown[4*d +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    m_bl = i_Blank_Lead;
    if (q == 21 && (m_pending || i_Load)) begin
      m_shown   = i_Load ? i_Digits : m_staged;
      m_pending = 1'b0;
      m_ack     = 1'b1;
    end else begin
      m_ack = 1'b0;
      if (i_Load) begin
        m_staged  = i_Digits;
        m_pending = 1'b1;
      end
    end
    q = (q + 1) % 24;
    track = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic goto(int target);
    do tick(); while (q != target);
  endtask

  always @(negedge clk) begin
    n_vec++;
    if ($countones(~o_Digit_En) > 1 || (o_Digit_En == 4'hF && o_Value !== 4'hF)) begin
      n_bad++;
      $display("FAIL invariant: en=%b val=%h, want at most one low and val=F when all off",
               o_Digit_En, o_Value);
    end
    if (track) begin
      n_vec++;
      if (o_Digit_En !== exp_en(q) || o_Value !== exp_val(q) || o_Load_Ack !== m_ack) begin
        n_bad++;
        $display("FAIL scan q=%0d: en=%b val=%h ack=%b, want en=%b val=%h ack=%b",
                 q, o_Digit_En, o_Value, o_Load_Ack, exp_en(q), exp_val(q), m_ack);
      end
      if (q % 6 == 0) cap_w[4*(q/6) +: 4] = o_Value;
      if (o_Load_Ack === 1'b1) ack_cnt++;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (o_Digit_En !== 4'hF || o_Value !== 4'hF || o_Load_Ack !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: en=%b val=%h ack=%b, want 1111 F 0", o_Digit_En, o_Value, o_Load_Ack);
    end
    #1;
    i_Rst_L = 1'b1;
  endtask

  task automatic test_scan();
    tick();
    n_vec++;
    if (o_Digit_En !== 4'hF) begin
      n_bad++; $display("FAIL first_blank: en=%b, want 1111", o_Digit_En);
    end
    tick();
    n_vec++;
    if (o_Digit_En !== 4'b1110 || o_Value !== 4'h0) begin
      n_bad++; $display("FAIL first_digit0: en=%b val=%h, want 1110 0", o_Digit_En, o_Value);
    end
    goto(21);
    goto(21);
    n_vec++;
    if (cap_w !== 16'h0000 || ack_cnt != 0) begin
      n_bad++; $display("FAIL idle_frame: digits=%h acks=%0d, want 0000 0", cap_w, ack_cnt);
    end
  endtask

  task automatic test_load_mid_frame();
    goto(5);
    i_Load = 1'b1; i_Digits = 16'h1234;
    tick();
    i_Load = 1'b0; i_Digits = 16'hABCD;
    goto(21);
    n_vec++;
    if (cap_w !== 16'h0000 || ack_cnt != 0) begin
      n_bad++; $display("FAIL tear_free: digits=%h acks=%0d, want 0000 0", cap_w, ack_cnt);
    end
    tick();
    n_vec++;
    if (o_Load_Ack !== 1'b1) begin
      n_bad++; $display("FAIL ack_pulse: ack=%b, want 1", o_Load_Ack);
    end
    goto(21);
    n_vec++;
    if (cap_w !== 16'h1234 || ack_cnt != 1) begin
      n_bad++; $display("FAIL new_value: digits=%h acks=%0d, want 1234 1", cap_w, ack_cnt);
    end
  endtask

  task automatic test_blank_lead();
    goto(5);
    i_Load = 1'b1; i_Digits = 16'h0050;
    tick();
    i_Load = 1'b0; i_Blank_Lead = 1'b1;
    goto(21);
    goto(21);
    n_vec++;
    if (cap_w !== 16'hFF50) begin
      n_bad++; $display("FAIL blank_lead_0050: digits=%h, want FF50", cap_w);
    end
    goto(5);
    i_Load = 1'b1; i_Digits = 16'h0000;
    tick();
    i_Load = 1'b0;
    goto(21);
    goto(21);
    n_vec++;
    if (cap_w !== 16'hFFF0) begin
      n_bad++; $display("FAIL blank_lead_0000: digits=%h, want FFF0", cap_w);
    end
    i_Blank_Lead = 1'b0;
    goto(21);
    n_vec++;
    if (cap_w !== 16'h0000) begin
      n_bad++; $display("FAIL no_blank_lead: digits=%h, want 0000", cap_w);
    end
  endtask

  task automatic test_back_to_back();
    goto(3);
    i_Load = 1'b1; i_Digits = 16'h1111;
    tick();
    i_Load = 1'b0;
    goto(10);
    i_Load = 1'b1; i_Digits = 16'h2222;
    tick();
    i_Load = 1'b0;
    ack_cnt = 0;
    goto(21);
    goto(21);
    n_vec++;
    if (cap_w !== 16'h2222 || ack_cnt != 1) begin
      n_bad++; $display("FAIL double_load: digits=%h acks=%0d, want 2222 1", cap_w, ack_cnt);
    end
    i_Load = 1'b1; i_Digits = 16'h5678;
    ack_cnt = 0;
    tick();
    i_Load = 1'b0;
    n_vec++;
    if (o_Load_Ack !== 1'b1) begin
      n_bad++; $display("FAIL boundary_ack: ack=%b, want 1", o_Load_Ack);
    end
    goto(21);
    n_vec++;
    if (cap_w !== 16'h5678 || ack_cnt != 1) begin
      n_bad++; $display("FAIL boundary_load: digits=%h acks=%0d, want 5678 1", cap_w, ack_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    goto(3);
    i_Load = 1'b1; i_Digits = 16'h9999;
    tick();
    i_Load = 1'b0;
    goto(13);
    n_vec++;
    if (o_Digit_En !== 4'b1011) begin
      n_bad++; $display("FAIL pre_reset_digit2: en=%b, want 1011", o_Digit_En);
    end
    #2;
    track = 1'b0;
    i_Rst_L = 1'b0;
    #1;
    n_vec++;
    if (o_Digit_En !== 4'hF || o_Value !== 4'hF || o_Load_Ack !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: en=%b val=%h ack=%b, want 1111 F 0", o_Digit_En, o_Value, o_Load_Ack);
    end
    @(negedge clk);
    #1;
    m_shown = 16'h0; m_staged = 16'h0; m_pending = 1'b0; m_ack = 1'b0;
    q = 22;
    ack_cnt = 0;
    i_Rst_L = 1'b1;
    tick();
    n_vec++;
    if (o_Digit_En !== 4'hF) begin
      n_bad++; $display("FAIL restart_blank: en=%b, want 1111", o_Digit_En);
    end
    tick();
    n_vec++;
    if (o_Digit_En !== 4'b1110) begin
      n_bad++; $display("FAIL restart_digit0: en=%b, want 1110", o_Digit_En);
    end
    goto(21);
    goto(21);
    n_vec++;
    if (cap_w !== 16'h0000 || ack_cnt != 0) begin
      n_bad++; $display("FAIL load_discarded: digits=%h acks=%0d, want 0000 0", cap_w, ack_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_mid_frame();
    test_blank_lead();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
